// File: rtl/bus_datapath_if.sv
// Control and bus bundle between the processor controller and the register-transfer datapath.
interface bus_datapath_if #(
  parameter int WIDTH = 8
);
  logic [7:0]       instruction;
  logic [15:0]      rout;
  logic [15:0]      ren;
  logic             addxor;
  logic [WIDTH-1:0] bus;
  logic             bus_conflict;
  logic             carry;
  logic             zero;

  modport master (
    output instruction, rout, ren, addxor,
    input  bus, bus_conflict, carry, zero
  );

  modport slave (
    input  instruction, rout, ren, addxor,
    output bus, bus_conflict, carry, zero
  );
endinterface

// File: rtl/bus_datapath.sv
// Shared-bus datapath: eight general registers, ALU operand latch A and result register G,
// driven each cycle by the controller's one-hot source select and sink enables.
module bus_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  bus_datapath_if.slave    ctl,
  input  logic [3:0]       debug_select,
  output logic [WIDTH-1:0] debug_value
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] sources [16];
  logic [WIDTH-1:0] bus_value;
  logic [4:0]       src_count;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             unused_ren_bits;

  assign unused_ren_bits = ^ctl.ren[15:10];

  always_comb begin
    for (int i = 0; i < 16; i++) sources[i] = '0;
    for (int i = 0; i < 8; i++) sources[i] = regs_q[i];
    sources[8]  = a_q;
    sources[9]  = g_q;
    sources[10] = WIDTH'(ctl.instruction);
  end

  // Selected drivers are wire-ORed so a conflicting select still yields a defined value.
  always_comb begin
    bus_value = '0;
    src_count = '0;
    for (int i = 0; i < 16; i++) begin
      if (ctl.rout[i]) begin
        bus_value = bus_value | sources[i];
        src_count = src_count + 5'd1;
      end
    end
  end

  assign ctl.bus          = bus_value;
  assign ctl.bus_conflict = (src_count >= 5'd2);
  assign ctl.carry        = carry_q;
  assign ctl.zero         = zero_q;

  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, bus_value};
    alu_result = '0;
    alu_carry  = 1'b0;
    if (ctl.addxor) begin
      alu_result = a_q ^ bus_value;
    end else begin
      alu_result = sum[WIDTH-1:0];
      alu_carry  = sum[WIDTH];
    end
  end

  // G always sees the pre-edge A, so a same-cycle A load does not disturb the ALU.
  always_comb begin
    for (int i = 0; i < 8; i++) regs_d[i] = ctl.ren[i] ? bus_value : regs_q[i];
    a_d     = ctl.ren[8] ? bus_value : a_q;
    g_d     = g_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (ctl.ren[9]) begin
      g_d     = alu_result;
      carry_d = alu_carry;
      zero_d  = (alu_result == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      a_q     <= '0;
      g_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      a_q     <= a_d;
      g_q     <= g_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    debug_value = '0;
    if (debug_select < 4'd8) begin
      debug_value = regs_q[debug_select[2:0]];
    end else if (debug_select == 4'd8) begin
      debug_value = a_q;
    end else if (debug_select == 4'd9) begin
      debug_value = g_q;
    end
  end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath with hand-computed register and flag values.
module tb_bus_datapath;

  logic       clock;
  logic       reset;
  logic [3:0] debug_select;
  logic [7:0] debug_value;
  int         check_count;
  int         pass_count;

  bus_datapath_if #(.WIDTH(8)) bif ();

  bus_datapath #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .ctl          (bif.slave),
    .debug_select (debug_select),
    .debug_value  (debug_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] instr, input logic [15:0] rout,
                               input logic [15:0] ren, input logic addxor);
    bif.instruction = instr;
    bif.rout        = rout;
    bif.ren         = ren;
    bif.addxor      = addxor;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clock);
    #1;
    bif.rout = '0;
    bif.ren  = '0;
    #1;
  endtask

  task automatic checkStorage(input string tag, input int sel, input logic [7:0] expected);
    debug_select = 4'(sel);
    #1;
    checkOutput(tag, 16'(debug_value), 16'(expected));
  endtask

  // Load an immediate into any set of sinks.
  task automatic loadImm(input logic [7:0] value, input logic [15:0] ren);
    applyStimulus(value, 16'h0400, ren, 1'b0);
    clockEdge();
  endtask

  initial begin
    check_count  = 0;
    pass_count   = 0;
    debug_select = '0;
    reset        = 1'b1;
    applyStimulus(8'h00, 16'h0000, 16'h0000, 1'b0);
    clockEdge();
    reset = 1'b0;
    #1;

    checkOutput("reset_bus", 16'(bif.bus), 16'h0000);
    checkOutput("reset_conflict", 16'(bif.bus_conflict), 16'h0000);
    checkOutput("reset_carry", 16'(bif.carry), 16'h0000);
    checkOutput("reset_zero", 16'(bif.zero), 16'h0000);
    for (int i = 0; i < 10; i++) checkStorage($sformatf("reset_dbg%0d", i), i, 8'h00);

    applyStimulus(8'hB1, 16'h0400, 16'h0001, 1'b0);
    checkOutput("imm_bus", 16'(bif.bus), 16'h00B1);
    clockEdge();
    checkStorage("imm_r0", 0, 8'hB1);

    applyStimulus(8'h00, 16'h0001, 16'h0084, 1'b0);
    checkOutput("move_bus", 16'(bif.bus), 16'h00B1);
    clockEdge();
    checkStorage("move_r2", 2, 8'hB1);
    checkStorage("move_r7", 7, 8'hB1);
    checkStorage("move_r0_kept", 0, 8'hB1);

    loadImm(8'hD7, 16'h0100);
    loadImm(8'h56, 16'h0002);
    checkStorage("a_loaded", 8, 8'hD7);
    applyStimulus(8'h00, 16'h0002, 16'h0200, 1'b0);
    clockEdge();
    checkStorage("add_g", 9, 8'h2D);
    checkOutput("add_carry", 16'(bif.carry), 16'h0001);
    checkOutput("add_zero", 16'(bif.zero), 16'h0000);

    applyStimulus(8'h00, 16'h0200, 16'h0008, 1'b0);
    clockEdge();
    checkStorage("g_to_r3", 3, 8'h2D);
    checkOutput("carry_held", 16'(bif.carry), 16'h0001);

    loadImm(8'h05, 16'h0110);
    applyStimulus(8'h00, 16'h0010, 16'h0200, 1'b1);
    clockEdge();
    checkStorage("xor_g", 9, 8'h00);
    checkOutput("xor_zero", 16'(bif.zero), 16'h0001);
    checkOutput("xor_carry", 16'(bif.carry), 16'h0000);

    loadImm(8'hF0, 16'h0001);
    loadImm(8'h0F, 16'h0002);
    applyStimulus(8'h00, 16'h0003, 16'h0020, 1'b0);
    checkOutput("conflict_flag", 16'(bif.bus_conflict), 16'h0001);
    checkOutput("conflict_bus", 16'(bif.bus), 16'h00FF);
    clockEdge();
    checkStorage("conflict_r5", 5, 8'hFF);
    checkOutput("single_no_conflict", 16'(bif.bus_conflict), 16'h0000);

    // A = 0x05: G must use the old A while A takes the bus value.
    applyStimulus(8'h10, 16'h0400, 16'h0300, 1'b0);
    clockEdge();
    checkStorage("ag_g_old_a", 9, 8'h15);
    checkStorage("ag_a_new", 8, 8'h10);

    applyStimulus(8'hF0, 16'h0400, 16'h0200, 1'b0);
    clockEdge();
    checkStorage("wrap_g", 9, 8'h00);
    checkOutput("wrap_carry", 16'(bif.carry), 16'h0001);
    checkOutput("wrap_zero", 16'(bif.zero), 16'h0001);

    applyStimulus(8'h00, 16'h0008, 16'h0008, 1'b0);
    clockEdge();
    checkStorage("self_reload_r3", 3, 8'h2D);

    applyStimulus(8'hAA, 16'h0800, 16'h0000, 1'b0);
    checkOutput("const_src_bus", 16'(bif.bus), 16'h0000);
    checkStorage("dbg_sel12", 12, 8'h00);

    reset = 1'b1;
    applyStimulus(8'h55, 16'h0400, 16'h03FF, 1'b0);
    clockEdge();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) checkStorage($sformatf("midreset_dbg%0d", i), i, 8'h00);
    checkOutput("midreset_carry", 16'(bif.carry), 16'h0000);
    checkOutput("midreset_zero", 16'(bif.zero), 16'h0000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
